// File: rtl/multiplier_module.sv
// Two-stage pipelined unsigned 8x8 multiplier returning the low byte of the product.
// Stage 1 registers truncated partial products; stage 2 reduces them (carry-save tree + ripple add) into zout.
module multiplier_module (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] zout
);

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] byte_t;

    // 3:2 compressor over 8-bit vectors; carries shift left and bit 7's carry falls off (mod 256).
    function automatic logic [2*DATA_W-1:0] csa(input byte_t x, input byte_t y, input byte_t z);
        byte_t s;
        byte_t maj;
        s   = x ^ y ^ z;
        maj = (x & y) | (x & z) | (y & z);
        return {maj[DATA_W-2:0], 1'b0, s};
    endfunction

    function automatic byte_t ripple_add(input byte_t x, input byte_t y);
        byte_t s;
        logic  cy;
        cy = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            s[i] = x[i] ^ y[i] ^ cy;
            cy   = (x[i] & y[i]) | (x[i] & cy) | (y[i] & cy);
        end
        return s;
    endfunction

    byte_t pp_d [DATA_W];
    byte_t pp_q [DATA_W];
    byte_t s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;
    byte_t zout_d;
    byte_t zout_q;

    always_comb begin
        for (int i = 0; i < DATA_W; i++) begin
            pp_d[i] = b[i] ? byte_t'(a << i) : '0;
        end
    end

    // ---- stage 1: partial-product registers ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DATA_W; i++) begin
                pp_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DATA_W; i++) begin
                pp_q[i] <= pp_d[i];
            end
        end
    end

    // Eight rows reduce 8 -> 6 -> 4 -> 3 -> 2 before the final carry-propagate add.
    always_comb begin
        {c0, s0} = csa(pp_q[0], pp_q[1], pp_q[2]);
        {c1, s1} = csa(pp_q[3], pp_q[4], pp_q[5]);
        {c2, s2} = csa(s0, c0, s1);
        {c3, s3} = csa(c1, pp_q[6], pp_q[7]);
        {c4, s4} = csa(s2, c2, s3);
        {c5, s5} = csa(s4, c4, c3);
        zout_d   = ripple_add(s5, c5);
    end

    // ---- stage 2: result register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zout_q <= '0;
        end else begin
            zout_q <= zout_d;
        end
    end

    assign zout = zout_q;

endmodule

// File: tb/tb_multiplier_module.sv
// Bench for multiplier_module: directed vector table, async-reset cases and a randomized
// stream with reset pulses, checked against a queue-based latency model of (a*b) mod 256.
module tb_multiplier_module;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] a   = 8'h00;
    logic [7:0] b   = 8'h00;
    logic [7:0] zout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] pipe[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    multiplier_module dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .zout (zout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_prod(input logic [7:0] x, input logic [7:0] y);
        int p;
        p = int'(x) * int'(y);
        return 8'(p % 256);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: zout=%02h expected=%02h at %0t", name, act, req, $time);
        end
    endtask

    // Wait one rising edge; the result visible after edge k is the product sampled at edge k-1.
    task automatic tick(output logic [7:0] exp);
        @(posedge clk);
        if (rst) begin
            pipe.push_back(ref_prod(a, b));
            exp = pipe.pop_front();
        end else begin
            pipe.delete();
            pipe.push_back(8'h00);
            exp = 8'h00;
        end
        #1;
    endtask

    task automatic reset_model();
        pipe.delete();
        pipe.push_back(8'h00);
    endtask

    initial begin
        vec_t       tbl[8];
        logic [7:0] e;
        int         hold;

        tbl[0] = '{8'hFF, 8'h55, 8'hAB};
        tbl[1] = '{8'h0F, 8'h00, 8'h00};
        tbl[2] = '{8'h00, 8'h02, 8'h00};
        tbl[3] = '{8'h0F, 8'h11, 8'hFF};
        tbl[4] = '{8'hFF, 8'hFF, 8'h01};
        tbl[5] = '{8'h10, 8'h10, 8'h00};
        tbl[6] = '{8'h01, 8'hC3, 8'hC3};
        tbl[7] = '{8'h03, 8'h05, 8'h0F};

        reset_model();
        rst = 1'b0;
        a   = 8'hFF;
        b   = 8'hFF;
        #1;
        check("reset_initial", zout, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick(e);
            check("reset_hold", zout, 8'h00);
        end

        // Release on a falling edge, then stream the table back to back.
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            rst = 1'b1;
            if (i < 8) begin
                a = tbl[i].a;
                b = tbl[i].b;
            end else begin
                a = 8'h00;
                b = 8'h00;
            end
            tick(e);
            if (i == 0) check("refill_zero", zout, 8'h00);
            else        check("table", zout, tbl[i-1].exp);
        end

        // Mid-stream asynchronous reset while zout is non-zero.
        @(negedge clk);
        a = 8'hFF;
        b = 8'h55;
        tick(e);
        @(negedge clk);
        a = 8'h03;
        b = 8'h05;
        tick(e);
        check("truncation", zout, 8'hAB);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("async_reset", zout, 8'h00);
        reset_model();
        tick(e);
        check("reset_mid_hold", zout, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        a   = 8'h07;
        b   = 8'h09;
        tick(e);
        check("post_release_zero", zout, 8'h00);
        @(negedge clk);
        a = 8'h00;
        b = 8'h00;
        tick(e);
        check("post_release_first", zout, 8'h3F);

        // Randomized stream with occasional reset pulses.
        hold = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            if (rst && $urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                #1;
                check("rand_async_reset", zout, 8'h00);
                reset_model();
                hold = $urandom_range(1, 3);
            end else if (!rst) begin
                if (hold > 0) hold--;
                if (hold == 0) rst = 1'b1;
            end
            a = 8'($urandom);
            b = 8'($urandom);
            tick(e);
            check("random", zout, e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
